top_memoria: RTL
================

TOP_MEMORIA -- requirements
Module: top_memoria

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- WIDTH_DATA_MEM, 32: data word width.
- CANT_REGISTROS, 32: register-file entries; register index width = clogb2(CANT_REGISTROS-1) = 5.
- CANT_BITS_ADDR_DATA, 10: word-address bits; memory depth = 2^CANT_BITS_ADDR_DATA words.
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- i_clock, in, 1: single clock, rising edge.
- i_soft_reset, in, 1: reset; asynchronous, active-low.
- i_enable_pipeline, in, 1: stage advance enable.
- i_result, in, WIDTH_DATA_MEM: EX result; byte address for memory ops.
- i_data_write_to_mem, in, WIDTH_DATA_MEM: store data.
- i_registro_destino, in, 5: destination register.
- i_RegWrite, in, 1: WB control, passed through.
- i_MemtoReg, in, 1: WB control, passed through.
- i_MemRead, in, 1: load request.
- i_MemWrite, in, 1: store request.
- i_size, in, 2: access size; 00 byte, 01 halfword, 10 word, 11 word.
- i_unsigned, in, 1: zero-extend loads when 1.
- o_RegWrite, out, 1: MEM/WB latched.
- o_MemtoReg, out, 1: MEM/WB latched.
- o_registro_destino, out, 5: MEM/WB latched.
- o_result, out, WIDTH_DATA_MEM: MEM/WB latched ALU result.
- o_read_data, out, WIDTH_DATA_MEM: MEM/WB latched, extended load data.
- i_debug_addr, in, CANT_BITS_ADDR_DATA: debug word address.
- o_debug_data, out, WIDTH_DATA_MEM: combinational read of mem[i_debug_addr].

Function
REQ-003 Word index = i_result[CANT_BITS_ADDR_DATA+1:2]; byte lane = i_result[1:0]; upper address bits are ignored, so addresses wrap modulo the memory size.
REQ-004 All state changes occur on the rising edge of i_clock when i_enable_pipeline=1; when it is 0, memory and all MEM/WB registers hold their values.
REQ-005 Store (i_MemWrite=1) writes only the selected lanes:
- byte: lane i_result[1:0] gets data[7:0].
- halfword: lanes {i_result[1],0} and {i_result[1],1} get data[15:0].
- word: all four lanes get data; i_result[1:0] is ignored.
REQ-006 Unaligned halfword (i_result[0]=1) and unaligned word accesses use the aligned container; no exception is raised.
REQ-007 The memory read is read-first: a load in the same cycle as a write to the same word returns the pre-write contents.
REQ-008 Load (i_MemRead=1) latches into o_read_data the selected byte or halfword, extended to WIDTH_DATA_MEM:
- sign-extended when i_unsigned=0;
- zero-extended when i_unsigned=1;
- word loads are taken unmodified.
REQ-009 When i_MemRead=0, o_read_data latches 0.
REQ-010 i_MemRead=1 together with i_MemWrite=1: the store executes and o_read_data gets the old contents, per REQ-007.
REQ-011 o_result, o_registro_destino, o_RegWrite and o_MemtoReg latch their inputs unchanged.
REQ-012 Latency is exactly one enabled clock from inputs to the MEM/WB outputs.
REQ-013 o_debug_data reflects writes from the cycle after the write edge.
REQ-014 Memory contents are not initialised; the verification bench initialises them before use.

Reset
REQ-015 i_soft_reset=0 asynchronously forces these outputs to 0, regardless of clock or enable: o_RegWrite, o_MemtoReg, o_registro_destino, o_result, o_read_data.
REQ-016 While reset is asserted, no memory write occurs; memory contents are preserved across reset.
REQ-017 After reset deasserts, the first enabled rising edge performs a normal stage update.

Verification
REQ-018 Store word 0xDEADBEEF at address 0x10, then load word from 0x10 -> o_read_data=0xDEADBEEF one clock after the load; o_debug_data at index 4 = 0xDEADBEEF.
REQ-019 With mem[4]=0xDEADBEEF, byte loads from 0x13 -> o_read_data=0xFFFFFFDE (signed) and 0x000000DE (i_unsigned=1).
REQ-020 Store byte 0x55 at 0x11 over 0xDEADBEEF -> word reads 0xDEAD55EF; store halfword 0x1234 at 0x12 -> word reads 0x123455EF.
REQ-021 i_enable_pipeline=0 with i_MemWrite=1 and new inputs -> memory and all outputs unchanged; i_enable_pipeline=1 -> update on the next edge.
REQ-022 Simultaneous load and store of 0x0 to address 0x10 -> o_read_data holds the old word; the next load returns 0x0.
REQ-023 Assert reset between clock edges -> MEM/WB outputs go to 0 immediately and stored data survives; release reset, load -> old data returned.

Source files
------------

// File: rtl/top_memoria.sv
// MEM pipeline stage: byte-addressable data memory with sized, sign/zero-extending loads
// and the MEM/WB register bank. A debug port reads memory words combinationally.
module top_memoria #(
    parameter  int unsigned WIDTH_DATA_MEM      = 32,
    parameter  int unsigned CANT_REGISTROS      = 32,
    parameter  int unsigned CANT_BITS_ADDR_DATA = 10,
    localparam int unsigned REG_W               = $clog2(CANT_REGISTROS)
) (
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_enable_pipeline,
    input  logic [WIDTH_DATA_MEM-1:0]      i_result,
    input  logic [WIDTH_DATA_MEM-1:0]      i_data_write_to_mem,
    input  logic [REG_W-1:0]               i_registro_destino,
    input  logic                           i_RegWrite,
    input  logic                           i_MemtoReg,
    input  logic                           i_MemRead,
    input  logic                           i_MemWrite,
    input  logic [1:0]                     i_size,
    input  logic                           i_unsigned,
    output logic                           o_RegWrite,
    output logic                           o_MemtoReg,
    output logic [REG_W-1:0]               o_registro_destino,
    output logic [WIDTH_DATA_MEM-1:0]      o_result,
    output logic [WIDTH_DATA_MEM-1:0]      o_read_data,
    input  logic [CANT_BITS_ADDR_DATA-1:0] i_debug_addr,
    output logic [WIDTH_DATA_MEM-1:0]      o_debug_data
);

    localparam int unsigned LANES = WIDTH_DATA_MEM / 8;
    localparam int unsigned DEPTH = 1 << CANT_BITS_ADDR_DATA;

    logic [WIDTH_DATA_MEM-1:0] mem [DEPTH];

    logic [CANT_BITS_ADDR_DATA-1:0] word_idx;
    logic [1:0]                     lane;
    logic [WIDTH_DATA_MEM-1:0]      mem_word;
    logic [7:0]                     rd_byte;
    logic [15:0]                    rd_half;
    logic [LANES-1:0]               byte_en;
    logic [WIDTH_DATA_MEM-1:0]      wdata;
    logic                           unused_addr_bits;

    logic                           regwrite_d, regwrite_q;
    logic                           memtoreg_d, memtoreg_q;
    logic [REG_W-1:0]               rd_d, rd_q;
    logic [WIDTH_DATA_MEM-1:0]      result_d, result_q;
    logic [WIDTH_DATA_MEM-1:0]      read_data_d, read_data_q;

    // Upper address bits are dropped, so accesses wrap modulo the memory size.
    assign word_idx         = i_result[CANT_BITS_ADDR_DATA+1:2];
    assign lane             = i_result[1:0];
    assign unused_addr_bits = ^i_result[WIDTH_DATA_MEM-1:CANT_BITS_ADDR_DATA+2];

    assign mem_word = mem[word_idx];
    assign rd_byte  = mem_word[{lane, 3'b000} +: 8];
    assign rd_half  = mem_word[{lane[1], 4'b0000} +: 16];

    // Store data is replicated across lanes so each enabled lane picks its own slice.
    always_comb begin
        byte_en = '0;
        wdata   = i_data_write_to_mem;
        case (i_size)
            2'b00: begin
                byte_en[lane] = 1'b1;
                wdata         = {LANES{i_data_write_to_mem[7:0]}};
            end
            2'b01: begin
                byte_en[{lane[1], 1'b0}] = 1'b1;
                byte_en[{lane[1], 1'b1}] = 1'b1;
                wdata                    = {(LANES/2){i_data_write_to_mem[15:0]}};
            end
            default: byte_en = '1;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_soft_reset && i_enable_pipeline && i_MemWrite) begin
            for (int unsigned b = 0; b < LANES; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        read_data_d = '0;
        if (i_MemRead) begin
            case (i_size)
                2'b00:   read_data_d = {{(WIDTH_DATA_MEM-8){rd_byte[7] & ~i_unsigned}}, rd_byte};
                2'b01:   read_data_d = {{(WIDTH_DATA_MEM-16){rd_half[15] & ~i_unsigned}}, rd_half};
                default: read_data_d = mem_word;
            endcase
        end
    end

    assign regwrite_d = i_RegWrite;
    assign memtoreg_d = i_MemtoReg;
    assign rd_d       = i_registro_destino;
    assign result_d   = i_result;

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            regwrite_q  <= 1'b0;
            memtoreg_q  <= 1'b0;
            rd_q        <= '0;
            result_q    <= '0;
            read_data_q <= '0;
        end else if (i_enable_pipeline) begin
            regwrite_q  <= regwrite_d;
            memtoreg_q  <= memtoreg_d;
            rd_q        <= rd_d;
            result_q    <= result_d;
            read_data_q <= read_data_d;
        end
    end

    assign o_RegWrite         = regwrite_q;
    assign o_MemtoReg         = memtoreg_q;
    assign o_registro_destino = rd_q;
    assign o_result           = result_q;
    assign o_read_data        = read_data_q;
    assign o_debug_data       = mem[i_debug_addr];

endmodule
